// File: rtl/i2s_mic_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : i2s_mic_rx
//  Description : I2S master receiver for a single MEMS microphone. Generates
//                SCK/WS, synchronizes the serial data line and delivers one
//                24-bit signed sample per frame for the selected slot.
//
//  Ports       : clk_i          - sole clock, rising edge
//                rst_i          - asynchronous active-high reset
//                enable_i       - run request; low holds the receiver idle
//                sd_i           - serial data from the mic (asynchronous)
//                sck_o          - I2S bit clock (2*CLK_DIV clk_i per period)
//                ws_o           - I2S word select (0 = left, 1 = right)
//                sample_o       - last received 24-bit word, MSB first
//                sample_valid_o - one-cycle strobe qualifying sample_o
//                sample_count_o - number of strobes issued, wrapping
//
//  Revision    : 1.0 - initial release
// ============================================================================
module i2s_mic_rx #(
    parameter int CLK_DIV = 8,   // clk_i cycles per SCK half-period, 4..255
    parameter int CHANNEL = 0    // 0 = left slot, 1 = right slot
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        enable_i,
    input  logic        sd_i,
    output logic        sck_o,
    output logic        ws_o,
    output logic [23:0] sample_o,
    output logic        sample_valid_o,
    output logic [15:0] sample_count_o
);

    localparam logic [7:0] c_DIV_LAST    = 8'(CLK_DIV - 1);
    localparam logic       c_CHANNEL_BIT = 1'(CHANNEL);
    localparam logic [4:0] c_SLOT_MSB    = 5'd1;
    localparam logic [4:0] c_SLOT_LSB    = 5'd24;

    // Registered state
    logic        r_sd_meta_q;
    logic        r_sd_s_q;
    logic [7:0]  r_div_cnt_q;
    logic        r_sck_q;
    logic [5:0]  r_bit_cnt_q;
    logic [23:0] r_shift_q;
    logic [23:0] r_sample_q;
    logic        r_sample_valid_q;
    logic [15:0] r_sample_count_q;

    // Next-state values
    logic [7:0]  w_div_cnt_d;
    logic        w_sck_d;
    logic [5:0]  w_bit_cnt_d;
    logic [23:0] w_shift_d;
    logic [23:0] w_sample_d;
    logic        w_sample_valid_d;
    logic [15:0] w_sample_count_d;

    // Decode
    logic        w_div_wrap;
    logic        w_fall_tick;
    logic [4:0]  w_slot;
    logic        w_in_word;
    logic        w_strobe;
    logic [23:0] w_shift_next;

    assign w_div_wrap   = (r_div_cnt_q == c_DIV_LAST);
    // A fall tick is the divider wrap while SCK is currently high.
    assign w_fall_tick  = enable_i && w_div_wrap && r_sck_q;
    assign w_slot       = r_bit_cnt_q[4:0];
    // One-bit I2S delay: period 0 of each slot carries no data.
    assign w_in_word    = (w_slot >= c_SLOT_MSB) && (w_slot <= c_SLOT_LSB);
    assign w_shift_next = {r_shift_q[22:0], r_sd_s_q};
    assign w_strobe     = w_fall_tick && (w_slot == c_SLOT_LSB)
                          && (r_bit_cnt_q[5] == c_CHANNEL_BIT);

    always_comb begin
        w_div_cnt_d      = r_div_cnt_q;
        w_sck_d          = r_sck_q;
        w_bit_cnt_d      = r_bit_cnt_q;
        w_shift_d        = r_shift_q;
        w_sample_d       = r_sample_q;
        w_sample_valid_d = 1'b0;
        w_sample_count_d = r_sample_count_q;

        if (!enable_i) begin
            // Idle: drop any partial word; sample and count are kept.
            w_div_cnt_d = 8'd0;
            w_sck_d     = 1'b0;
            w_bit_cnt_d = 6'd0;
            w_shift_d   = 24'd0;
        end else begin
            if (w_div_wrap) begin
                w_div_cnt_d = 8'd0;
                w_sck_d     = ~r_sck_q;
            end else begin
                w_div_cnt_d = r_div_cnt_q + 8'd1;
            end

            if (w_fall_tick) begin
                w_bit_cnt_d = r_bit_cnt_q + 6'd1;
                if (w_in_word) begin
                    w_shift_d = w_shift_next;
                end
                if (w_strobe) begin
                    w_sample_d       = w_shift_next;
                    w_sample_valid_d = 1'b1;
                    w_sample_count_d = r_sample_count_q + 16'd1;
                end
            end
        end
    end

    // Two-flop synchronizer for the asynchronous data line.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sd_meta_q <= 1'b0;
            r_sd_s_q    <= 1'b0;
        end else begin
            r_sd_meta_q <= sd_i;
            r_sd_s_q    <= r_sd_meta_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_div_cnt_q      <= 8'd0;
            r_sck_q          <= 1'b0;
            r_bit_cnt_q      <= 6'd0;
            r_shift_q        <= 24'd0;
            r_sample_q       <= 24'd0;
            r_sample_valid_q <= 1'b0;
            r_sample_count_q <= 16'd0;
        end else begin
            r_div_cnt_q      <= w_div_cnt_d;
            r_sck_q          <= w_sck_d;
            r_bit_cnt_q      <= w_bit_cnt_d;
            r_shift_q        <= w_shift_d;
            r_sample_q       <= w_sample_d;
            r_sample_valid_q <= w_sample_valid_d;
            r_sample_count_q <= w_sample_count_d;
        end
    end

    assign sck_o          = r_sck_q;
    // WS is the frame-half bit, so it only moves on fall ticks.
    assign ws_o           = r_bit_cnt_q[5];
    assign sample_o       = r_sample_q;
    assign sample_valid_o = r_sample_valid_q;
    assign sample_count_o = r_sample_count_q;

endmodule
`default_nettype wire

// File: doc/i2s_mic_rx.md
I2S_MIC_RX -- requirements
Module: i2s_mic_rx

Interface
REQ-001 Parameter CLK_DIV, default 8: clk_i cycles per SCK half-period; legal range 4..255.
REQ-002 Parameter CHANNEL, default 0: slot delivered; 0 = left (ws_o low), 1 = right (ws_o high).
REQ-003 clk_i  in  1  sole clock; all state on rising edge.
REQ-004 rst_i  in  1  reset, asynchronous assert, active-high.
REQ-005 enable_i  in  1  run request; low holds the receiver idle.
REQ-006 sd_i  in  1  serial data from the I2S microphone, asynchronous to clk_i.
REQ-007 sck_o  out  1  I2S bit clock to the microphone.
REQ-008 ws_o  out  1  I2S word select to the microphone.
REQ-009 sample_o  out  24  signed two's-complement sample, MSB first on the wire; feeds the envelope stage's sample_i.
REQ-010 sample_valid_o  out  1  one-cycle strobe qualifying sample_o; feeds the envelope stage's sample_valid_i.
REQ-011 sample_count_o  out  16  count of strobes issued, wraps 0xFFFF -> 0x0000.

Function
REQ-012 sd_i SHALL pass through a 2-flop synchronizer (sd_s) before any use.
REQ-013 Divider div_cnt SHALL hold 0 while enable_i is low; when enabled, at div_cnt == CLK_DIV-1 it wraps to 0 and sck_o toggles, otherwise it increments.
REQ-014 Ticks: rise tick = edge where sck_o goes 0->1; fall tick = edge where sck_o goes 1->0; SCK period = 2*CLK_DIV clk_i cycles.
REQ-015 6-bit bit_cnt SHALL increment, wrapping 63 -> 0, on every fall tick; frame = 64 SCK periods = 128*CLK_DIV clk_i cycles.
REQ-016 ws_o SHALL equal bit_cnt[5], so WS changes only on fall ticks; slot index s = bit_cnt[4:0] at the tick, before increment.
REQ-017 1-bit I2S delay: the slot MSB is in SCK period s = 1; the LSB is in s = 24; periods s = 0 and 25..31 are ignored.
REQ-018 On a fall tick with 1 <= s <= 24, shift register SHALL load {shift[22:0], sd_s}; the sampled value lies in the SCK high phase, valid for CLK_DIV >= 4.
REQ-019 On the fall tick with s == 24 and bit_cnt[5] == CHANNEL, all of the following SHALL occur on the same edge:
- sample_o <= {shift[22:0], sd_s}
- sample_valid_o <= 1
- sample_count_o increments
REQ-020 sample_valid_o SHALL be high for exactly one clk_i cycle per frame; the non-selected slot SHALL never strobe.
REQ-021 sample_o SHALL hold its value between strobes; no sign manipulation (bit 23 of the wire word is the sign).
REQ-022 enable_i low SHALL synchronously force all of the following; sample_o and sample_count_o hold:
- div_cnt, bit_cnt and shift to 0
- sck_o and ws_o to 0
- sample_valid_o to 0
REQ-023 Disable mid-frame SHALL discard the partial word with no strobe; re-enable SHALL start a fresh frame at bit_cnt = 0, s = 0.
REQ-024 enable_i falling on the same edge as an s == 24 fall tick SHALL suppress the strobe, because disable wins.
REQ-025 Timing: counting enabled edges from 1, the first rise tick is at edge CLK_DIV and fall ticks are at edges 2*CLK_DIV*(s+1) for each slot s of the frame.

Reset
REQ-026 rst_i high SHALL asynchronously clear all of the following:
- div_cnt, bit_cnt, shift, sd_s
- sck_o, ws_o, sample_valid_o
- sample_o (0x000000) and sample_count_o (0x0000)
REQ-027 Release of rst_i SHALL be synchronous in effect; the first counting edge is the first clk_i edge after deassertion with enable_i high.
REQ-028 Reset mid-frame SHALL behave as REQ-023 and SHALL additionally clear the outputs.

Verification
REQ-029 Timing, CLK_DIV=8, CHANNEL=0, mic model drives left word 0x800001:
- sck_o period is 16 cycles and ws_o period is 1024 cycles.
- sample_valid_o goes high after enabled edge 400, for 1 cycle.
- sample_o = 0x800001 and sample_count_o = 1.
REQ-030 Channel select: left word 0x123456, right word 0xABCDEF, CHANNEL=1 -> only 0xABCDEF strobed, after edge 912 (2*8*57), once per 1024 cycles.
REQ-031 Disable at edge 200 mid-slot, then re-enable -> no strobe in the aborted frame, sck_o/ws_o low while disabled, next sample_o intact, sample_count_o unchanged by the abort.
REQ-032 rst_i pulsed asynchronously between clk_i edges mid-frame -> all outputs 0 immediately; first post-reset strobe 400 enabled edges later.
REQ-033 Count wrap: force sample_count_o near 0xFFFF, run 2 frames -> 0xFFFF -> 0x0000 -> 0x0001.
REQ-034 Metastability/CDC: sd_i edges jittered ±2 clk_i cycles around fall ticks, CLK_DIV=4 -> every strobed word matches the model word.
